instr_stream_loader: RTL and testbench

Instruction encoder/loader for the single-cycle MIPS core: accepts symbolic instruction descriptors (mnemonic code plus register/immediate fields) over a valid/ready stream, encodes each into the 32-bit MIPS word that the main control decoder consumes, and writes the words sequentially into instruction memory. It sits between the bench/boot source and the instruction memory write port, and runs while the core is held idle.

---
 rtl/instr_stream_loader.sv | 135 +++++++++++++
 tb/tb_instr_stream_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_stream_loader.sv
// Encodes symbolic MIPS instruction descriptors into 32-bit words and writes them
// sequentially into instruction memory, one word per two cycles.
module instr_stream_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_op,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    input  logic                  in_last,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] LP_BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST = {ADDR_WIDTH{1'b1}};

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_error;
    logic                  r_last;

    logic [31:0]           w_enc;
    logic                  w_op_valid;

    // Handshake: a descriptor is consumed on a rising edge where in_valid && in_ready;
    // the source must hold it stable until then.
    always_comb begin
        w_op_valid = 1'b1;
        w_enc      = 32'h0;
        case (in_op)
            5'd0:  w_enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100000};
            5'd1:  w_enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100010};
            5'd2:  w_enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100100};
            5'd3:  w_enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100101};
            5'd4:  w_enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100110};
            5'd5:  w_enc = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b101010};
            5'd6:  w_enc = {6'b000000, in_rs, 15'b0, 6'b001000};
            5'd7:  w_enc = {6'b100011, in_rs, in_rt, in_imm};
            5'd8:  w_enc = {6'b101011, in_rs, in_rt, in_imm};
            5'd9:  w_enc = {6'b000100, in_rs, in_rt, in_imm};
            5'd10: w_enc = {6'b000101, in_rs, in_rt, in_imm};
            5'd11: w_enc = {6'b001000, in_rs, in_rt, in_imm};
            5'd12: w_enc = {6'b001100, in_rs, in_rt, in_imm};
            5'd13: w_enc = {6'b001101, in_rs, in_rt, in_imm};
            5'd14: w_enc = {6'b001110, in_rs, in_rt, in_imm};
            5'd15: w_enc = {6'b001010, in_rs, in_rt, in_imm};
            5'd16: w_enc = {6'b001011, in_rs, in_rt, in_imm};
            5'd17: w_enc = {6'b001111, 5'b0, in_rt, in_imm};
            5'd18: w_enc = {6'b000010, in_target};
            5'd19: w_enc = {6'b000011, in_target};
            default: w_op_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= LP_BASE;
            r_wdata <= 32'h0;
            r_count <= '0;
            r_error <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_addr  <= LP_BASE;
                        r_count <= '0;
                        r_error <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (w_op_valid) begin
                            r_wdata <= w_enc;
                            r_last  <= in_last;
                            r_state <= S_WRITE;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_WRITE: begin
                    r_count <= r_count + (ADDR_WIDTH+1)'(1);
                    if (r_last) begin
                        r_state <= S_DONE;
                    end else if (r_addr == LP_LAST) begin
                        // Top word just written and the stream still wants more.
                        r_error <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_addr  <= r_addr + ADDR_WIDTH'(1);
                        r_state <= S_LOAD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == S_LOAD);
    assign imem_we    = (r_state == S_WRITE);
    assign busy       = (r_state == S_LOAD) || (r_state == S_WRITE);
    assign done       = (r_state == S_DONE);
    assign error      = r_error;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_instr_stream_loader.sv
// Directed bench for instr_stream_loader: a default-size instance (a) and a
// four-word instance (b) for the memory-full boundary.
module tb_instr_stream_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic [4:0]  in_op = '0, in_rs = '0, in_rt = '0, in_rd = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        in_last = 1'b0;

    logic        ready_a, we_a, busy_a, done_a, error_a;
    logic [7:0]  addr_a;
    logic [31:0] wdata_a;
    logic [8:0]  count_a;
    logic [1:0]  state_a;

    logic        ready_b, we_b, busy_b, done_b, error_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  count_b;
    logic [1:0]  state_b;

    int checks = 0;
    int failures = 0;
    logic [39:0] exp_q_a[$];
    logic [39:0] exp_q_b[$];
    int waits;

    instr_stream_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .in_valid(valid_a), .in_ready(ready_a),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .imem_we(we_a), .imem_addr(addr_a),
        .imem_wdata(wdata_a), .count(count_a), .busy(busy_a), .done(done_a),
        .error(error_a), .dbg_state(state_a)
    );

    instr_stream_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .in_valid(valid_b), .in_ready(ready_b),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .imem_we(we_b), .imem_addr(addr_b),
        .imem_wdata(wdata_b), .count(count_b), .busy(busy_b), .done(done_b),
        .error(error_b), .dbg_state(state_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (we_a) begin
            if (exp_q_a.size() == 0) check("spurious_we_a", {31'b0, we_a}, 32'd0);
            else begin
                logic [39:0] e;
                e = exp_q_a.pop_front();
                check("addr_a", {24'b0, addr_a}, {24'b0, e[39:32]});
                check("wdata_a", wdata_a, e[31:0]);
            end
        end
        if (we_b) begin
            if (exp_q_b.size() == 0) check("spurious_we_b", {31'b0, we_b}, 32'd0);
            else begin
                logic [39:0] e;
                e = exp_q_b.pop_front();
                check("addr_b", {30'b0, addr_b}, {24'b0, e[39:32]});
                check("wdata_b", wdata_b, e[31:0]);
            end
        end
    end

    task automatic pulse_start(input bit sel);
        @(posedge clk); #1;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
    endtask

    // Called at posedge+#1; returns at posedge+#1 of the accepting edge.
    task automatic send(input bit sel, input logic [4:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic last, output int w);
        logic acc, r;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_target = tgt; in_last = last;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        acc = 1'b0; w = 0;
        while (!acc && w < 50) begin
            @(negedge clk);
            r = sel ? ready_b : ready_a;
            @(posedge clk); #1;
            if (r) acc = 1'b1; else w++;
        end
        valid_a = 1'b0; valid_b = 1'b0;
        check("accept", {31'b0, acc}, 32'd1);
    endtask

    task automatic put(input bit sel, input logic [4:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic last, input logic [7:0] a,
                       input logic [31:0] d, output int w);
        if (sel) exp_q_b.push_back({a, d}); else exp_q_a.push_back({a, d});
        send(sel, op, rs, rt, rd, imm, tgt, last, w);
    endtask

    task automatic wait_done(input bit sel);
        logic d;
        d = 1'b0;
        for (int i = 0; i < 20 && !d; i++) begin
            @(negedge clk);
            d = sel ? done_b : done_a;
        end
        check(sel ? "done_b" : "done_a", {31'b0, d}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_ready", {31'b0, ready_a}, 0);
        check("rst_we", {31'b0, we_a}, 0);
        check("rst_busy", {31'b0, busy_a}, 0);
        check("rst_done", {31'b0, done_a}, 0);
        check("rst_error", {31'b0, error_a}, 0);
        check("rst_addr", {24'b0, addr_a}, 0);
        check("rst_wdata", wdata_a, 0);
        check("rst_count", {23'b0, count_a}, 0);
        check("rst_state", {30'b0, state_a}, 0);
        @(negedge clk); reset = 1'b0;

        // Single ADDI session
        pulse_start(0);
        put(0, 5'd11, 5'd0, 5'd8, 5'd0, 16'd5, 26'd0, 1'b1, 8'd0, 32'h20080005, waits);
        @(negedge clk);
        check("we_after_accept", {31'b0, we_a}, 1);
        check("ready_in_write", {31'b0, ready_a}, 0);
        wait_done(0);
        check("t1_error", {31'b0, error_a}, 0);
        check("t1_count", {23'b0, count_a}, 1);
        check("t1_busy", {31'b0, busy_a}, 0);

        // Four-word stream with back-to-back valid
        pulse_start(0);
        put(0, 5'd0, 5'd8, 5'd9, 5'd10, 16'd0, 26'd0, 1'b0, 8'd0, 32'h01095020, waits);
        put(0, 5'd6, 5'd31, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0, 8'd1, 32'h03E00008, waits);
        check("stall_jr", waits, 1);
        put(0, 5'd9, 5'd8, 5'd9, 5'd0, 16'hFFFF, 26'd0, 1'b0, 8'd2, 32'h1109FFFF, waits);
        check("stall_beq", waits, 1);
        put(0, 5'd18, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10, 1'b1, 8'd3, 32'h08000010, waits);
        check("stall_j", waits, 1);
        wait_done(0);
        check("t2_count", {23'b0, count_a}, 4);
        check("t2_error", {31'b0, error_a}, 0);

        // LUI ignores rs, SW, JAL; source stall and a start ignored in LOAD
        pulse_start(0);
        put(0, 5'd17, 5'd5, 5'd3, 5'd0, 16'h1234, 26'd0, 1'b0, 8'd0, 32'h3C031234, waits);
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stall_count", {23'b0, count_a}, 1);
        check("stall_ready", {31'b0, ready_a}, 1);
        check("stall_busy", {31'b0, busy_a}, 1);
        @(posedge clk); #1;
        put(0, 5'd8, 5'd29, 5'd31, 5'd0, 16'h0004, 26'd0, 1'b0, 8'd1, 32'hAFBF0004, waits);
        put(0, 5'd19, 5'd0, 5'd0, 5'd0, 16'd0, 26'h3FFFFFF, 1'b1, 8'd2, 32'h0FFFFFFF, waits);
        wait_done(0);
        check("t3_count", {23'b0, count_a}, 3);

        // Invalid op as second descriptor
        pulse_start(0);
        put(0, 5'd1, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 8'd0, 32'h00221822, waits);
        send(0, 5'd25, 5'd1, 5'd1, 5'd1, 16'hFFFF, 26'd0, 1'b0, waits);
        wait_done(0);
        check("t4_error", {31'b0, error_a}, 1);
        check("t4_count", {23'b0, count_a}, 1);

        // Reset during WRITE
        pulse_start(0);
        put(0, 5'd11, 5'd0, 5'd8, 5'd0, 16'd5, 26'd0, 1'b0, 8'd0, 32'h20080005, waits);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check("mid_rst_we", {31'b0, we_a}, 0);
        check("mid_rst_busy", {31'b0, busy_a}, 0);
        check("mid_rst_count", {23'b0, count_a}, 0);
        check("mid_rst_addr", {24'b0, addr_a}, 0);
        check("mid_rst_wdata", wdata_a, 0);
        check("mid_rst_state", {30'b0, state_a}, 0);
        @(negedge clk); reset = 1'b0;
        pulse_start(0);
        put(0, 5'd14, 5'd4, 5'd5, 5'd0, 16'hA5A5, 26'd0, 1'b1, 8'd0, 32'h3885A5A5, waits);
        wait_done(0);
        check("t5_count", {23'b0, count_a}, 1);
        check("t5_error", {31'b0, error_a}, 0);

        // Small memory: fills without last
        pulse_start(1);
        for (int i = 0; i < 4; i++)
            put(1, 5'd2, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0, 1'b0, 8'(i), 32'h00210824, waits);
        wait_done(1);
        check("full_error", {31'b0, error_b}, 1);
        check("full_count", {29'b0, count_b}, 4);
        @(posedge clk); #1;
        valid_b = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("fifth_ready", {31'b0, ready_b}, 0);
        check("fifth_count", {29'b0, count_b}, 4);
        valid_b = 1'b0;

        // Small memory: last on the fourth word
        pulse_start(1);
        for (int i = 0; i < 4; i++)
            put(1, 5'd12, 5'd2, 5'd3, 5'd0, 16'h00F0, 26'd0, logic'(i == 3), 8'(i),
                32'h304300F0, waits);
        wait_done(1);
        check("last4_error", {31'b0, error_b}, 0);
        check("last4_count", {29'b0, count_b}, 4);

        repeat (3) @(negedge clk);
        check("exp_q_a_empty", exp_q_a.size(), 0);
        check("exp_q_b_empty", exp_q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
